div_ctrl: RTL and testbench



---
 rtl/div_ctrl.sv | 116 +++++++++++
 tb/tb_div_ctrl.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/div_ctrl.sv
// Multi-cycle sequencer around the combinational div32 array divider: latches signed
// operands, holds their magnitudes while the array settles, then returns a sign-corrected quotient.

module div32 (
   input  logic [31:0] dividendshort,
   input  logic [31:0] divisor,
   output logic [31:0] quotient
);
   logic [32:0] rem;

   // Restoring long division, one quotient bit per unrolled stage.
   always_comb begin
      rem      = '0;
      quotient = '0;
      for (int unsigned i = 0; i < 32; i++) begin
         rem = {rem[31:0], dividendshort[31 - i]};
         if (rem >= {1'b0, divisor}) begin
            rem             = rem - {1'b0, divisor};
            quotient[31 - i] = 1'b1;
         end
      end
   end
endmodule

module div_ctrl #(
   parameter int unsigned SETTLE_CYCLES = 4,
   parameter int unsigned CNT_W         = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        ctrl_DIV,
   input  logic [31:0] data_operandA,
   input  logic [31:0] data_operandB,
   output logic [31:0] data_result,
   output logic        data_exception,
   output logic        data_resultRDY,
   output logic        busy
);
   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t            state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              sgn_q;
   logic              zero_q;
   logic [31:0]       mag_a_q;
   logic [31:0]       mag_b_q;
   logic [31:0]       quot_q;
   logic [31:0]       result_q;
   logic              exc_q;
   logic              rdy_q;

   logic [31:0]       mag_a_d;
   logic [31:0]       mag_b_d;
   logic [31:0]       div_q;

   always_comb begin
      mag_a_d = data_operandA[31] ? (32'd0 - data_operandA) : data_operandA;
      mag_b_d = data_operandB[31] ? (32'd0 - data_operandB) : data_operandB;
   end

   div32 u_div32 (
      .dividendshort (mag_a_q),
      .divisor       (mag_b_q),
      .quotient      (div_q)
   );

   // Outputs update on the DONE-exit edge, so a restart landing on DONE cannot
   // overwrite the result that accompanies the old operation's ready pulse.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         sgn_q    <= 1'b0;
         zero_q   <= 1'b0;
         mag_a_q  <= '0;
         mag_b_q  <= '0;
         quot_q   <= '0;
         result_q <= '0;
         exc_q    <= 1'b0;
         rdy_q    <= 1'b0;
      end else begin
         rdy_q <= 1'b0;
         if (state_q == S_DONE) begin
            rdy_q    <= 1'b1;
            result_q <= zero_q ? '0 : quot_q;
            exc_q    <= zero_q;
         end
         if (ctrl_DIV) begin
            sgn_q   <= data_operandA[31] ^ data_operandB[31];
            mag_a_q <= mag_a_d;
            mag_b_q <= mag_b_d;
            cnt_q   <= CNT_W'(SETTLE_CYCLES - 1);
            zero_q  <= (data_operandB == '0);
            state_q <= (data_operandB == '0) ? S_DONE : S_BUSY;
         end else begin
            case (state_q)
               S_BUSY: begin
                  if (cnt_q == '0) begin
                     quot_q  <= sgn_q ? (32'd0 - div_q) : div_q;
                     state_q <= S_DONE;
                  end else begin
                     cnt_q <= cnt_q - 1'b1;
                  end
               end
               S_DONE:  state_q <= S_IDLE;
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   assign data_result    = result_q;
   assign data_exception = exc_q;
   assign data_resultRDY = rdy_q;
   assign busy           = (state_q == S_BUSY);
endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: directed corner cases plus random operands
// compared against an arithmetic reference of signed division.

module tb_div_ctrl;
   localparam int unsigned SETTLE = 4;
   localparam int unsigned LAT    = SETTLE + 1;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        ctrl_DIV = 1'b0;
   logic [31:0] data_operandA = '0;
   logic [31:0] data_operandB = '0;
   logic [31:0] data_result;
   logic        data_exception;
   logic        data_resultRDY;
   logic        busy;

   int checks = 0;
   int errors = 0;

   div_ctrl #(.SETTLE_CYCLES(SETTLE), .CNT_W(4)) dut (
      .clock          (clock),
      .reset          (reset),
      .ctrl_DIV       (ctrl_DIV),
      .data_operandA  (data_operandA),
      .data_operandB  (data_operandB),
      .data_result    (data_result),
      .data_exception (data_exception),
      .data_resultRDY (data_resultRDY),
      .busy           (busy)
   );

   always #5 clock = ~clock;

   function automatic logic [31:0] ref_quot(input logic [31:0] a, input logic [31:0] b);
      if (b == 32'd0) return 32'd0;
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
      return 32'($signed(a) / $signed(b));
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic start(input logic [31:0] a, input logic [31:0] b);
      @(negedge clock);
      ctrl_DIV      = 1'b1;
      data_operandA = a;
      data_operandB = b;
      @(posedge clock);
      #1 ctrl_DIV = 1'b0;
   endtask

   // Samples after edges 0..L+1 of an operation whose sampling edge just passed.
   task automatic check_op(input string tag, input logic [31:0] a, input logic [31:0] b);
      int unsigned lat;
      logic        zero;
      zero = (b == 32'd0);
      lat  = zero ? 1 : LAT;
      for (int unsigned k = 0; k <= lat + 1; k++) begin
         @(negedge clock);
         check({tag, " rdy"}, {31'd0, data_resultRDY}, {31'd0, k == lat});
         check({tag, " busy"}, {31'd0, busy}, {31'd0, !zero && k < SETTLE});
         if (k >= lat) begin
            check({tag, " result"}, data_result, ref_quot(a, b));
            check({tag, " exc"}, {31'd0, data_exception}, {31'd0, zero});
         end
      end
   endtask

   task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b);
      start(a, b);
      check_op(tag, a, b);
   endtask

   initial begin
      logic [31:0] ra, rb;

      // Reset state
      #2;
      check("rst result", data_result, 32'd0);
      check("rst exc", {31'd0, data_exception}, 32'd0);
      check("rst rdy", {31'd0, data_resultRDY}, 32'd0);
      check("rst busy", {31'd0, busy}, 32'd0);
      @(negedge clock);
      reset = 1'b0;

      run_op("pp", 32'd100, 32'd7);
      run_op("np", 32'hFFFF_FF9C, 32'd7);
      run_op("pn", 32'd100, 32'hFFFF_FFF9);
      run_op("nn", 32'hFFFF_FF9C, 32'hFFFF_FFF9);
      run_op("dz", 32'd55, 32'd0);
      run_op("after dz", 32'd81, 32'd9);
      run_op("ovf", 32'h8000_0000, 32'hFFFF_FFFF);
      run_op("max", 32'h7FFF_FFFF, 32'd1);
      run_op("small", 32'd3, 32'd5);

      // Restart mid-BUSY: aborted op must not pulse ready
      start(32'd100, 32'd7);
      for (int i = 0; i < 2; i++) begin
         @(negedge clock);
         check("abort rdy", {31'd0, data_resultRDY}, 32'd0);
      end
      run_op("restart", 32'd9, 32'd3);

      // Reset mid-BUSY
      start(32'd1000, 32'd10);
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1;
      #1;
      check("midrst result", data_result, 32'd0);
      check("midrst exc", {31'd0, data_exception}, 32'd0);
      check("midrst busy", {31'd0, busy}, 32'd0);
      @(negedge clock);
      reset = 1'b0;
      for (int i = 0; i < LAT + 2; i++) begin
         @(negedge clock);
         check("midrst rdy", {31'd0, data_resultRDY}, 32'd0);
      end
      run_op("post rst", 32'd1000, 32'd10);

      // Restart landing on DONE: old ready still pulses with old result
      start(32'd20, 32'd4);
      for (int i = 0; i < SETTLE + 1; i++) @(negedge clock);
      ctrl_DIV      = 1'b1;
      data_operandA = 32'd21;
      data_operandB = 32'd0;
      @(posedge clock);
      #1 ctrl_DIV = 1'b0;
      @(negedge clock);
      check("done+start rdy", {31'd0, data_resultRDY}, 32'd1);
      check("done+start result", data_result, 32'd5);
      check("done+start exc", {31'd0, data_exception}, 32'd0);
      check("done+start busy", {31'd0, busy}, 32'd0);
      @(negedge clock);
      check("new dz rdy", {31'd0, data_resultRDY}, 32'd1);
      check("new dz result", data_result, 32'd0);
      check("new dz exc", {31'd0, data_exception}, 32'd1);

      // Random operands
      for (int i = 0; i < 24; i++) begin
         ra = $urandom;
         case ($urandom_range(0, 3))
            0:       rb = 32'd0;
            1:       rb = 32'($signed($urandom_range(0, 40)) - 20);
            default: rb = $urandom >> $urandom_range(0, 31);
         endcase
         if ($urandom_range(0, 1) == 1) ra = ra >> $urandom_range(0, 31);
         run_op("rand", ra, rb);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
